bus_mux_arb: RTL and testbench
==============================

Name: bus_mux_arb

Overview:
- Parametrised N-channel, WIDTH-bit bus multiplexer with a registered output stage and valid/ready handshakes on every port.
- Source choice is runtime-selectable:
  - explicit select, where a `sel` input picks the source, or
  - round-robin arbitration across requesting channels.
- Sits between the register file, ALU and memory-data sources and the shared 8-bit data bus.
- Replaces the bare select-driven data mux with a clocked, back-pressure-aware one.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH), select/source index width (derived; do not override).
- CNTW, 16, transfer counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel request/valid.
- in_ready  out  NCH  per-channel accept; combinational.
- sel  in  SELW  explicit source index (mode_rr=0).
- mode_rr  in  1  0 = explicit select, 1 = round-robin.
- out_data  out  WIDTH  registered bus data.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  downstream accept.
- out_src  out  SELW  channel index of the word in out_data.
- xfer_cnt  out  CNTW  count of input transfers accepted since reset.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - out_data=0, out_valid=0, out_src=0, xfer_cnt=0.
  - rr_ptr=NCH-1, so channel 0 has first priority after reset.
  - All in_ready are 0 while rst_n is low.
- load_en = !out_valid || out_ready. The output register may load when empty or when drained in the same cycle (full throughput, one word per cycle).
- Grant, combinational:
  - Explicit mode: grant=sel when sel<NCH and in_valid[sel]=1. Otherwise there is no grant. Out-of-range sel never grants and never indexes past in_data.
  - RR mode: grant is the first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, … with wrap modulo NCH. rr_ptr itself is searched last.
- in_ready[i] = load_en && grant_valid && grant==i. At most one bit is set. in_ready does not depend on in_valid of other channels beyond the grant logic.
- Transfer on channel i (in_valid[i] && in_ready[i]) at edge k:
  - out_data <= in_data[i]; out_src <= i; out_valid <= 1.
  - xfer_cnt <= xfer_cnt+1, wrapping at 2^CNTW-1 -> 0.
  - In RR mode, rr_ptr <= i. In explicit mode, rr_ptr is unchanged.
- Latency: input word appears on out_data one cycle after acceptance.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_src hold their last values.
- out_valid=1 and out_ready=0: out_data and out_src are held stable, and all in_ready are 0.
- Simultaneous drain and load in one cycle: the new word replaces the old one, and out_valid stays 1.
- Mode or sel change: takes effect on the next grant evaluation. It never disturbs a word already held in the output register. rr_ptr is retained across mode switches.
- No requesting channel: no grant, and out_valid follows the drain rule.
- Reset asserted mid-transfer: the held word is discarded and all state returns to reset values immediately.

Decomposition:
- Shared package bus_pkg:
  - MODE_SEL=1'b0, MODE_RR=1'b1.
  - Default BUS_WIDTH=8.
- One sub-module, rr_arbiter (params NCH, SELW):
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: gnt_idx[SELW], gnt_valid.
  - Purely combinational rotate-priority search.
  - The top holds rr_ptr, the output register and the counter.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 with all in_valid=1.
   - Response: out_valid=0, out_data=0, xfer_cnt=0, in_ready=0000. After release with mode_rr=1, the first accept is channel 0.
2. Explicit mode:
   - Stimulus: in_data ch2=0xA5, sel=2, in_valid=0100, out_ready=1.
   - Response: in_ready=0100, next cycle out_data=0xA5, out_src=2, xfer_cnt=1. Then sel=1 with in_valid[1]=0 gives no grant, and out_valid drops to 0.
3. Round-robin fairness:
   - Stimulus: in_valid=1111 held, out_ready=1, channel i data=0x10+i.
   - Response: out_src sequence 0,1,2,3,0,… with out_data 0x10,0x11,0x12,0x13,0x10. Sparse in_valid=1010 gives the sequence 1,3,1,3.
4. Back-pressure:
   - Stimulus: out_ready=0 after one transfer of 0x3C.
   - Response: out_data stays 0x3C, out_valid=1, in_ready=0000 for all stalled cycles. Raising out_ready accepts the next word the same cycle.
5. Counter wrap, mode switch and async reset:
   - Counter: with CNTW=4, 17 transfers give xfer_cnt=1.
   - Mode switch: from RR mode with rr_ptr=2, switching to explicit sel=0 grants channel 0. Returning to RR resumes at channel 3.
   - Async reset: pulsing rst_n low mid-stream clears out_valid without waiting for a clock edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants for the bus multiplexer/arbiter slice.
package bus_pkg;

  localparam logic MODE_SEL  = 1'b0;
  localparam logic MODE_RR   = 1'b1;
  localparam int   BUS_WIDTH = 8;

endpackage

// File: rtl/bus_mux_arb_if.sv
// Channel-side and bus-side handshake signals of bus_mux_arb, grouped as one interface.
interface bus_mux_arb_if #(
  parameter int WIDTH = bus_pkg::BUS_WIDTH,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH),
  parameter int CNTW  = 16
);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic                 mode_rr;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_src;
  logic [CNTW-1:0]      xfer_cnt;

  modport master (
    output in_data, in_valid, sel, mode_rr, out_ready,
    input  in_ready, out_data, out_valid, out_src, xfer_cnt
  );

  modport slave (
    input  in_data, in_valid, sel, mode_rr, out_ready,
    output in_ready, out_data, out_valid, out_src, xfer_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: first requester after ptr, ptr itself last.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    // Walk the distance from farthest to nearest so the closest requester wins.
    for (int k = NCH; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NCH]) begin
        gnt_idx   = SELW'((int'(ptr) + k) % NCH);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_mux_arb.sv
// N-channel registered bus mux with explicit-select or round-robin source choice.
module bus_mux_arb
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH),
  parameter int CNTW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_mux_arb_if.slave  bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic [CNTW-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [SELW-1:0]  rr_idx;
  logic             rr_valid;
  logic             sel_valid;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // Matching sel against each legal index keeps out-of-range values from granting.
  always_comb begin
    sel_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.sel == SELW'(i) && bus.in_valid[i]) sel_valid = 1'b1;
    end
  end

  assign grant_idx   = (bus.mode_rr == MODE_RR) ? rr_idx   : bus.sel;
  assign grant_valid = (bus.mode_rr == MODE_RR) ? rr_valid : sel_valid;
  assign load_en     = !out_valid_q || bus.out_ready;
  assign xfer        = |(bus.in_ready & bus.in_valid);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign bus.in_ready[gi] = rst_n && load_en && grant_valid && (grant_idx == SELW'(gi));
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == SELW'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      xfer_cnt_d  = xfer_cnt_q + CNTW'(1);
      if (bus.mode_rr == MODE_RR) rr_ptr_d = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      xfer_cnt_q  <= '0;
      rr_ptr_q    <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      xfer_cnt_q  <= xfer_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed-vector bench for bus_mux_arb (4 channels, 8-bit data, 4-bit counter).
module tb_bus_mux_arb;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;
  localparam int CNTW  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cnt_exp = 0;

  always #5 clk = ~clk;

  bus_mux_arb_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .CNTW(CNTW)) bus ();

  bus_mux_arb #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] val);
    bus.in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  // One accepted word: checks registered outputs one edge after acceptance.
  task automatic expect_xfer(input string tag, input int src, input logic [7:0] data);
    step();
    cnt_exp = (cnt_exp + 1) % 16;
    check_vec({tag, "_src"},   32'(bus.out_src), 32'(src));
    check_vec({tag, "_data"},  32'(bus.out_data), 32'(data));
    check_vec({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_vec({tag, "_cnt"},   32'(bus.xfer_cnt), 32'(cnt_exp));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.mode_rr   = 1'b1;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) set_ch(i, 8'(8'h10 + i));

    // Reset held across an edge with every channel requesting.
    step();
    check_vec("rst_valid", 32'(bus.out_valid), 32'd0);
    check_vec("rst_data",  32'(bus.out_data),  32'd0);
    check_vec("rst_cnt",   32'(bus.xfer_cnt),  32'd0);
    check_vec("rst_ready", 32'(bus.in_ready),  32'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_vec("rr_first_ready", 32'(bus.in_ready), 32'b0001);
    expect_xfer("rr0", 0, 8'h10);

    // Round-robin, all channels requesting.
    for (int k = 1; k <= 4; k++) expect_xfer("rr_full", k % 4, 8'(8'h10 + (k % 4)));

    // Sparse requests 1010 starting after rr_ptr=0.
    @(negedge clk);
    bus.in_valid = 4'b1010;
    expect_xfer("rr_sp", 1, 8'h11);
    expect_xfer("rr_sp", 3, 8'h13);
    expect_xfer("rr_sp", 1, 8'h11);
    expect_xfer("rr_sp", 3, 8'h13);

    // Explicit select of channel 2.
    @(negedge clk);
    bus.mode_rr  = 1'b0;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b0100;
    set_ch(2, 8'hA5);
    #1;
    check_vec("sel2_ready", 32'(bus.in_ready), 32'b0100);
    expect_xfer("sel2", 2, 8'hA5);

    // Selecting an idle channel: no grant, output drains.
    @(negedge clk);
    bus.sel = 2'd1;
    #1;
    check_vec("sel1_ready", 32'(bus.in_ready), 32'b0000);
    step();
    check_vec("drain_valid", 32'(bus.out_valid), 32'd0);
    check_vec("drain_data",  32'(bus.out_data),  32'hA5);
    check_vec("drain_src",   32'(bus.out_src),   32'd2);
    check_vec("drain_cnt",   32'(bus.xfer_cnt),  32'(cnt_exp));

    // Back-pressure after a 0x3C transfer.
    @(negedge clk);
    bus.sel      = 2'd0;
    bus.in_valid = 4'b0001;
    set_ch(0, 8'h3C);
    expect_xfer("bp_load", 0, 8'h3C);
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_ch(0, 8'h55);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_vec("bp_ready", 32'(bus.in_ready), 32'b0000);
      step();
      check_vec("bp_data",  32'(bus.out_data),  32'h3C);
      check_vec("bp_valid", 32'(bus.out_valid), 32'd1);
      check_vec("bp_cnt",   32'(bus.xfer_cnt),  32'(cnt_exp));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check_vec("bp_release_ready", 32'(bus.in_ready), 32'b0001);
    expect_xfer("bp_next", 0, 8'h55);

    // Park rr_ptr at 2, switch to explicit sel=0, then back to RR.
    @(negedge clk);
    bus.mode_rr  = 1'b1;
    bus.in_valid = 4'b0100;
    set_ch(2, 8'h12);
    expect_xfer("ptr2", 2, 8'h12);
    @(negedge clk);
    bus.mode_rr  = 1'b0;
    bus.sel      = 2'd0;
    bus.in_valid = 4'b1111;
    #1;
    check_vec("sw_sel_ready", 32'(bus.in_ready), 32'b0001);
    expect_xfer("sw_sel", 0, 8'h55);
    @(negedge clk);
    bus.mode_rr = 1'b1;
    #1;
    check_vec("sw_rr_ready", 32'(bus.in_ready), 32'b1000);
    expect_xfer("sw_rr", 3, 8'h13);

    // Transfers 16 and 17 wrap the 4-bit counter to 1.
    expect_xfer("wrap", 0, 8'h55);
    expect_xfer("wrap", 1, 8'h11);
    check_vec("wrap_cnt_is_1", 32'(bus.xfer_cnt), 32'd1);

    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("arst_valid", 32'(bus.out_valid), 32'd0);
    check_vec("arst_data",  32'(bus.out_data),  32'd0);
    check_vec("arst_cnt",   32'(bus.xfer_cnt),  32'd0);
    check_vec("arst_ready", 32'(bus.in_ready),  32'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_vec("arst_rr_ready", 32'(bus.in_ready), 32'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
